// File: rtl/program_memory_loader_pkg.sv
// Shared constants and loader state encodings for the program memory loader.
package program_memory_loader_pkg;

  localparam int PML_DATA_WIDTH = 16;
  localparam int PML_ADDR_WIDTH = 5;
  localparam int PML_DEPTH      = 32;

  typedef enum logic [2:0] {
    LOAD_HI = 3'd0,
    LOAD_LO = 3'd1,
    FILL    = 3'd2,
    RUN     = 3'd3,
    HALTED  = 3'd4
  } loader_state_e;

  // Only the two byte-assembly states take bytes from the stream.
  function automatic logic loader_accepts(loader_state_e s);
    return (s == LOAD_HI) || (s == LOAD_LO);
  endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte-stream load handshake plus the core-side memory port and control flags.
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic [7:0]            load_byte;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  halted;
  logic                  start_execution;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_error;

  // The loader/memory side.
  modport slave (
    input  load_byte, load_valid, load_last, mem_addr, mem_write_data, mem_write, halted,
    output load_ready, mem_read_data, start_execution, load_count, load_error
  );

  // The stream source and the core.
  modport master (
    output load_byte, load_valid, load_last, mem_addr, mem_write_data, mem_write, halted,
    input  load_ready, mem_read_data, start_execution, load_count, load_error
  );
endinterface

// File: rtl/program_memory_loader_word_ram_32x16.sv
// Single-write-port word RAM: synchronous write, asynchronous read.
module word_ram_32x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on the edge; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Zero-latency read; a same-cycle write is only visible after the edge.
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/program_memory_loader.sv
// Loads a big-endian byte stream into the unified memory, zero-fills the rest,
// then releases the core and serves its memory port until it halts.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = PML_DATA_WIDTH,
  parameter int ADDR_WIDTH = PML_ADDR_WIDTH,
  parameter int DEPTH      = PML_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  program_memory_loader_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_C  = DEPTH_C - ONE_C;

  loader_state_e         state_q;
  logic [ADDR_WIDTH:0]   ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  ready_q;
  logic                  start_q;
  logic                  error_q;
  logic [7:0]            hi_q;

  logic                  xfer;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v == DEPTH_C) ? v : v + ONE_C;
  endfunction

  assign xfer = bus.load_valid & ready_q;

  // Single RAM write port, owned by the loader or the core depending on state.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr_q[ADDR_WIDTH-1:0];
    ram_wdata = '0;
    case (state_q)
      LOAD_HI: if (xfer && bus.load_last) begin
        ram_we    = 1'b1;
        ram_wdata = {bus.load_byte, 8'h00};
      end
      LOAD_LO: if (xfer) begin
        ram_we    = 1'b1;
        ram_wdata = {hi_q, bus.load_byte};
      end
      FILL:    ram_we = (ptr_q != DEPTH_C);
      RUN: if (bus.mem_write) begin
        ram_we    = 1'b1;
        ram_waddr = bus.mem_addr;
        ram_wdata = bus.mem_write_data;
      end
      default: ;
    endcase
  end

  // Loader sequencing with registered handshake and control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD_HI;
      ptr_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      error_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        LOAD_HI: if (xfer) begin
          hi_q <= bus.load_byte;
          if (bus.load_last) begin
            // Odd-length stream: the lone high byte becomes a padded word.
            ptr_q   <= ptr_q + ONE_C;
            count_q <= sat_inc(count_q);
            error_q <= 1'b1;
            state_q <= FILL;
            ready_q <= loader_accepts(FILL);
          end else begin
            state_q <= LOAD_LO;
          end
        end
        LOAD_LO: if (xfer) begin
          ptr_q   <= ptr_q + ONE_C;
          count_q <= sat_inc(count_q);
          if (bus.load_last) begin
            state_q <= FILL;
            ready_q <= loader_accepts(FILL);
          end else if (ptr_q == LAST_C) begin
            // Memory full without a terminating byte.
            error_q <= 1'b1;
            state_q <= FILL;
            ready_q <= loader_accepts(FILL);
          end else begin
            state_q <= LOAD_HI;
          end
        end
        FILL: begin
          if (ptr_q == DEPTH_C) begin
            state_q <= RUN;
          end else begin
            ptr_q <= ptr_q + ONE_C;
            if (ptr_q == LAST_C) state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.halted) begin
            state_q <= HALTED;
            start_q <= 1'b0;
          end else begin
            start_q <= 1'b1;
          end
        end
        HALTED: begin
          start_q <= 1'b0;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= HALTED;
          start_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  word_ram_32x16 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.mem_addr),
    .rdata_o (bus.mem_read_data)
  );

  assign bus.load_ready      = ready_q;
  assign bus.start_execution = start_q;
  assign bus.load_count      = count_q;
  assign bus.load_error      = error_q;
endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: load scenarios, fill timing,
// core write/read port, halt and mid-load reset.
module tb_program_memory_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;

  program_memory_loader_if bus ();

  program_memory_loader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.halted     = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer one byte, optionally after idle cycles, and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clock);
    @(negedge clock);
    bus.load_byte  = b;
    bus.load_valid = 1'b1;
    bus.load_last  = last;
    n = 0;
    while (!bus.load_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("send accepted", {31'd0, bus.load_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  // Count rising edges from the current point until start_execution is seen.
  task automatic wait_start(output int n);
    n = 0;
    while (!bus.start_execution && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
    @(negedge clock);
    bus.mem_addr = a;
    #1;
    chk(name, {16'd0, bus.mem_read_data}, {16'd0, exp});
  endtask

  rd_vec_t   img_a [6];
  logic [7:0] stream_d [64];
  int        cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    img_a[0] = '{5'd0,  16'h1234};
    img_a[1] = '{5'd1,  16'h5678};
    img_a[2] = '{5'd2,  16'h0000};
    img_a[3] = '{5'd3,  16'h0000};
    img_a[4] = '{5'd17, 16'h0000};
    img_a[5] = '{5'd31, 16'h0000};
    for (int i = 0; i < 64; i++) stream_d[i] = 8'(i * 7 + 3);

    bus.load_byte      = '0;
    bus.load_valid     = 1'b0;
    bus.load_last      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.halted         = 1'b0;

    // Reset state
    do_reset();
    chk("reset load_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("reset load_count", {26'd0, bus.load_count}, 32'd0);
    chk("reset start", {31'd0, bus.start_execution}, 32'd0);
    chk("reset load_error", {31'd0, bus.load_error}, 32'd0);

    // Four-byte program, back-to-back
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h56, 1'b0, 0);
    send_byte(8'h78, 1'b1, 0);
    chk("A ready low in fill", {31'd0, bus.load_ready}, 32'd0);
    chk("A start low in fill", {31'd0, bus.start_execution}, 32'd0);
    wait_start(cyc);
    chk("A edges to start", cyc, 32'd31);
    chk("A load_count", {26'd0, bus.load_count}, 32'd2);
    chk("A load_error", {31'd0, bus.load_error}, 32'd0);
    for (int i = 0; i < 6; i++) read_chk("A image", img_a[i].addr, img_a[i].exp);

    // Same program, throttled, with a byte offered during fill
    do_reset();
    send_byte(8'h12, 1'b0, 1);
    send_byte(8'h34, 1'b0, 1);
    send_byte(8'h56, 1'b0, 1);
    send_byte(8'h78, 1'b1, 1);
    @(negedge clock);
    bus.load_byte  = 8'hFF;
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    wait_start(cyc);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("B edges to start", cyc, 32'd31);
    chk("B load_count", {26'd0, bus.load_count}, 32'd2);
    chk("B load_error", {31'd0, bus.load_error}, 32'd0);
    for (int i = 0; i < 6; i++) read_chk("B image", img_a[i].addr, img_a[i].exp);

    // Odd stream: single high byte marked last
    do_reset();
    send_byte(8'hAB, 1'b1, 0);
    wait_start(cyc);
    chk("C edges to start", cyc, 32'd32);
    chk("C load_error", {31'd0, bus.load_error}, 32'd1);
    chk("C load_count", {26'd0, bus.load_count}, 32'd1);
    read_chk("C mem0", 5'd0, 16'hAB00);
    read_chk("C mem1", 5'd1, 16'h0000);

    // 64 bytes without a terminator: memory full, fill skipped
    do_reset();
    for (int i = 0; i < 64; i++) send_byte(stream_d[i], 1'b0, 0);
    chk("D ready low", {31'd0, bus.load_ready}, 32'd0);
    wait_start(cyc);
    chk("D edges to start", cyc, 32'd2);
    chk("D load_count", {26'd0, bus.load_count}, 32'd32);
    chk("D load_error", {31'd0, bus.load_error}, 32'd1);
    for (int w = 0; w < 32; w++)
      read_chk("D image", 5'(w), {stream_d[2*w], stream_d[2*w+1]});

    // Core write in RUN: old value before the edge, new value after
    @(negedge clock);
    bus.mem_addr       = 5'd5;
    bus.mem_write_data = 16'hBEEF;
    bus.mem_write      = 1'b1;
    #1;
    chk("E read before edge", {16'd0, bus.mem_read_data}, {16'd0, stream_d[10], stream_d[11]});
    @(posedge clock);
    #1;
    bus.mem_write = 1'b0;
    chk("E read after edge", {16'd0, bus.mem_read_data}, 32'h0000BEEF);

    // Core write while loading is ignored
    do_reset();
    @(negedge clock);
    bus.mem_addr       = 5'd5;
    bus.mem_write_data = 16'h1111;
    bus.mem_write      = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    bus.mem_write = 1'b0;
    chk("E write ignored in load", {16'd0, bus.mem_read_data}, 32'h0000BEEF);

    // Short program, then halt
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b1, 0);
    wait_start(cyc);
    chk("F edges to start", cyc, 32'd32);
    @(negedge clock);
    bus.halted = 1'b1;
    @(posedge clock);
    #1;
    chk("F start drops on halt", {31'd0, bus.start_execution}, 32'd0);
    @(negedge clock);
    bus.halted         = 1'b0;
    bus.mem_addr       = 5'd3;
    bus.mem_write_data = 16'hCAFE;
    bus.mem_write      = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    bus.mem_write = 1'b0;
    chk("F write ignored halted", {16'd0, bus.mem_read_data}, 32'd0);
    chk("F ready low halted", {31'd0, bus.load_ready}, 32'd0);
    chk("F start stays low", {31'd0, bus.start_execution}, 32'd0);
    read_chk("F mem0", 5'd0, 16'h1234);

    // Reset in the middle of a word discards the high byte
    do_reset();
    send_byte(8'h99, 1'b0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("G ready after reset", {31'd0, bus.load_ready}, 32'd1);
    chk("G count after reset", {26'd0, bus.load_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b1, 0);
    wait_start(cyc);
    chk("G load_count", {26'd0, bus.load_count}, 32'd1);
    chk("G load_error", {31'd0, bus.load_error}, 32'd0);
    read_chk("G mem0", 5'd0, 16'h1122);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
